// File: rtl/tick_timer_bank_pkg.sv
// Shared definitions for the tick timer bank: channel modes, FSM state
// encoding and the prescaler ratio helper.
package tick_timer_pkg;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic int calc_pre(input longint f0, input longint f_tick);
    return int'(f0 / f_tick);
  endfunction

endpackage

// File: rtl/tick_timer_bank_if.sv
// Configuration/control and status bundle of the tick timer bank.
interface tick_timer_bank_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 16
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [CNT_W-1:0] wr_period;
  logic             wr_mode;
  logic [NCH-1:0]   start;
  logic [NCH-1:0]   stop;
  logic [NCH-1:0]   irq_clr;
  logic             tick;
  logic [NCH-1:0]   busy;
  logic [NCH-1:0]   expire;
  logic [NCH-1:0]   irq_pend;

  modport master (
    output wr_en, wr_ch, wr_period, wr_mode, start, stop, irq_clr,
    input  tick, busy, expire, irq_pend
  );

  modport slave (
    input  wr_en, wr_ch, wr_period, wr_mode, start, stop, irq_clr,
    output tick, busy, expire, irq_pend
  );
endinterface

// File: rtl/tick_timer_bank_channel.sv
// One timer channel: config registers, IDLE/RUN FSM, tick-driven down
// counter, registered expire pulse and sticky interrupt-pending flag.
module timer_channel
  import tick_timer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_i,
  input  logic             wr_sel_i,
  input  logic [CNT_W-1:0] wr_period_i,
  input  logic             wr_mode_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             irq_clr_i,
  output logic             busy_o,
  output logic             expire_o,
  output logic             irq_pend_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             mode_q, mode_d;
  logic             expire_q, expire_d;
  logic             irq_q, irq_d;
  logic [CNT_W-1:0] per_eff_s;
  logic             mode_eff_s;

  // Channel state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      period_q <= {CNT_W{1'b0}};
      mode_q   <= MODE_ONESHOT;
      expire_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      expire_q <= expire_d;
      irq_q    <= irq_d;
    end
  end

  // Next state: a same-cycle write is visible to start; reload uses the stored period
  always_comb begin
    per_eff_s  = wr_sel_i ? wr_period_i : period_q;
    mode_eff_s = wr_sel_i ? wr_mode_i : mode_q;
    period_d   = per_eff_s;
    mode_d     = mode_eff_s;
    state_d    = state_q;
    cnt_d      = cnt_q;
    expire_d   = 1'b0;
    irq_d      = irq_q & ~irq_clr_i;
    case (state_q)
      ST_IDLE: begin
        if (start_i && (per_eff_s != {CNT_W{1'b0}})) begin
          state_d = ST_RUN;
          cnt_d   = per_eff_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stop_i) begin
          state_d = ST_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end else if (start_i && (per_eff_s != {CNT_W{1'b0}})) begin
          cnt_d = per_eff_s;
        end else if (tick_i) begin
          if (cnt_q > {{(CNT_W-1){1'b0}}, 1'b1}) begin
            cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            expire_d = 1'b1;
            irq_d    = 1'b1;
            if ((mode_q == MODE_PERIODIC) && (period_q != {CNT_W{1'b0}})) begin
              cnt_d = period_q;
            end else begin
              state_d = ST_IDLE;
              cnt_d   = {CNT_W{1'b0}};
            end
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  assign busy_o     = (state_q == ST_RUN);
  assign expire_o   = expire_q;
  assign irq_pend_o = irq_q;

endmodule

// File: rtl/tick_timer_bank.sv
// Timer bank top: free-running prescaler producing a shared tick and
// NCH independent programmable timer channels.
module tick_timer_bank
  import tick_timer_pkg::*;
#(
  parameter longint F0     = 50_000_000,
  parameter longint F_TICK = 1_000_000,
  parameter int     NCH    = 4,
  parameter int     CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  tick_timer_bank_if.slave  bus
);

  localparam int PRE   = calc_pre(F0, F_TICK);
  localparam int PRE_W = (PRE > 1) ? $clog2(PRE) : 1;
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;

  if ((F_TICK <= 0) || ((F0 % F_TICK) != 0) || (PRE < 1) || (NCH < 1) || (NCH > 16))
  begin : g_bad_params
    $error("tick_timer_bank: illegal F0/F_TICK/NCH combination");
  end

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick_s;
  logic [NCH-1:0]   wr_sel_s;
  logic [NCH-1:0]   busy_s;
  logic [NCH-1:0]   expire_s;
  logic [NCH-1:0]   irq_s;

  // Prescaler counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= {PRE_W{1'b0}};
    end else begin
      pre_q <= pre_d;
    end
  end

  // Prescaler wraps at PRE-1
  always_comb begin
    if (pre_q == PRE_W'(PRE - 1)) begin
      pre_d = {PRE_W{1'b0}};
    end else begin
      pre_d = pre_q + {{(PRE_W-1){1'b0}}, 1'b1};
    end
  end

  // Gated by rst_n so a PRE of 1 still shows tick low during reset
  assign tick_s = rst_n & (pre_q == PRE_W'(PRE - 1));

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign wr_sel_s[i] = bus.wr_en & (bus.wr_ch == CH_W'(i));

    timer_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick_i      (tick_s),
      .wr_sel_i    (wr_sel_s[i]),
      .wr_period_i (bus.wr_period),
      .wr_mode_i   (bus.wr_mode),
      .start_i     (bus.start[i]),
      .stop_i      (bus.stop[i]),
      .irq_clr_i   (bus.irq_clr[i]),
      .busy_o      (busy_s[i]),
      .expire_o    (expire_s[i]),
      .irq_pend_o  (irq_s[i])
    );
  end

  assign bus.tick     = tick_s;
  assign bus.busy     = busy_s;
  assign bus.expire   = expire_s;
  assign bus.irq_pend = irq_s;

endmodule

// File: tb/tb_tick_timer_bank.sv
// Directed bench: a PRE=4 four-channel bank plus a PRE=1 three-channel
// bank for the out-of-range channel write and constant-tick cases.
module tb_tick_timer_bank;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  int   cyc;

  tick_timer_bank_if #(.NCH(4), .CNT_W(16)) b0 ();
  tick_timer_bank_if #(.NCH(3), .CNT_W(16)) b1 ();

  tick_timer_bank #(.F0(50_000_000), .F_TICK(12_500_000), .NCH(4), .CNT_W(16)) dut0 (
    .clk (clk), .rst_n (rst_n), .bus (b0)
  );
  tick_timer_bank #(.F0(50_000_000), .F_TICK(50_000_000), .NCH(3), .CNT_W(16)) dut1 (
    .clk (clk), .rst_n (rst_n), .bus (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg0(input int ch, input int per, input logic mode);
    b0.wr_en = 1'b1; b0.wr_ch = 2'(ch); b0.wr_period = 16'(per); b0.wr_mode = mode;
    step();
    b0.wr_en = 1'b0;
  endtask

  task automatic cfg1(input int ch, input int per, input logic mode);
    b1.wr_en = 1'b1; b1.wr_ch = 2'(ch); b1.wr_period = 16'(per); b1.wr_mode = mode;
    step();
    b1.wr_en = 1'b0;
  endtask

  task automatic start0(input int ch);
    b0.start[ch] = 1'b1;
    step();
    b0.start = 4'b0000;
  endtask

  task automatic wait_exp0(input int ch, input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget; k++) begin
      step();
      if (b0.expire[ch]) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_tick0();
    for (int k = 0; k < 8; k++) begin
      if (b0.tick) break;
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b0.wr_en = 1'b0; b0.wr_ch = 2'd0; b0.wr_period = 16'd0; b0.wr_mode = 1'b0;
    b0.start = 4'b0000; b0.stop = 4'b0000; b0.irq_clr = 4'b0000;
    b1.wr_en = 1'b0; b1.wr_ch = 2'd0; b1.wr_period = 16'd0; b1.wr_mode = 1'b0;
    b1.start = 3'b000; b1.stop = 3'b000; b1.irq_clr = 3'b000;
    repeat (3) step();
    n_cmp++; if (b0.tick !== 1'b0) begin n_bad++; $display("FAIL rst_tick got %b want 0", b0.tick); end
    n_cmp++; if (b0.busy !== 4'b0000) begin n_bad++; $display("FAIL rst_busy got %b want 0000", b0.busy); end
    n_cmp++; if (b0.expire !== 4'b0000) begin n_bad++; $display("FAIL rst_expire got %b want 0000", b0.expire); end
    n_cmp++; if (b0.irq_pend !== 4'b0000) begin n_bad++; $display("FAIL rst_irq got %b want 0000", b0.irq_pend); end
    n_cmp++; if (b1.tick !== 1'b0) begin n_bad++; $display("FAIL rst_tick1 got %b want 0", b1.tick); end
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_cmp++;
      if (b0.tick !== ((k % 4) == 3)) begin
        n_bad++; $display("FAIL pre_tick edge %0d got %b want %b", k, b0.tick, ((k % 4) == 3));
      end
    end
    n_cmp++; if (b1.tick !== 1'b1) begin n_bad++; $display("FAIL pre1_tick got %b want 1", b1.tick); end
  endtask

  task automatic test_oneshot();
    int st, at, extra;
    cfg0(0, 3, 1'b0);
    start0(0);
    st = cyc;
    n_cmp++; if (b0.busy[0] !== 1'b1) begin n_bad++; $display("FAIL os_busy got %b want 1", b0.busy[0]); end
    wait_exp0(0, 30, at);
    n_cmp++;
    if (at < 0 || (at - st) < 9 || (at - st) > 12) begin
      n_bad++; $display("FAIL os_latency got %0d want 9..12", (at < 0) ? -1 : at - st);
    end
    n_cmp++; if (b0.irq_pend[0] !== 1'b1) begin n_bad++; $display("FAIL os_irq got %b want 1", b0.irq_pend[0]); end
    n_cmp++; if (b0.busy[0] !== 1'b0) begin n_bad++; $display("FAIL os_idle got %b want 0", b0.busy[0]); end
    extra = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (b0.expire[0]) extra++;
    end
    n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL os_extra got %0d want 0", extra); end
  endtask

  task automatic test_periodic();
    int a[6];
    int want[5] = '{8, 8, 8, 20, 20};
    cfg0(1, 2, 1'b1);
    start0(1);
    wait_exp0(1, 40, a[0]);
    wait_exp0(1, 40, a[1]);
    wait_exp0(1, 40, a[2]);
    cfg0(1, 5, 1'b1);
    wait_exp0(1, 40, a[3]);
    wait_exp0(1, 40, a[4]);
    wait_exp0(1, 40, a[5]);
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (a[k] < 0 || a[k+1] < 0 || (a[k+1] - a[k]) != want[k]) begin
        n_bad++; $display("FAIL per_interval %0d got %0d want %0d", k, a[k+1] - a[k], want[k]);
      end
    end
    b0.stop[1] = 1'b1; step(); b0.stop = 4'b0000;
    n_cmp++; if (b0.busy[1] !== 1'b0) begin n_bad++; $display("FAIL per_stop got %b want 0", b0.busy[1]); end
  endtask

  task automatic test_priority();
    int extra, r, at;
    cfg0(2, 4, 1'b1);
    start0(2);
    repeat (5) step();
    b0.start[2] = 1'b1; b0.stop[2] = 1'b1;
    step();
    b0.start = 4'b0000; b0.stop = 4'b0000;
    n_cmp++; if (b0.busy[2] !== 1'b0) begin n_bad++; $display("FAIL pri_busy got %b want 0", b0.busy[2]); end
    extra = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (b0.expire[2]) extra++;
    end
    n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL pri_expire got %0d want 0", extra); end
    cfg0(2, 0, 1'b0);
    start0(2);
    n_cmp++; if (b0.busy[2] !== 1'b0) begin n_bad++; $display("FAIL zero_per got %b want 0", b0.busy[2]); end
    cfg0(2, 1, 1'b0);
    start0(2);
    wait_tick0();
    start0(2);
    r = cyc;
    n_cmp++; if (b0.expire[2] !== 1'b0) begin n_bad++; $display("FAIL restart_expire got %b want 0", b0.expire[2]); end
    n_cmp++; if (b0.busy[2] !== 1'b1) begin n_bad++; $display("FAIL restart_busy got %b want 1", b0.busy[2]); end
    wait_exp0(2, 10, at);
    n_cmp++; if (at - r !== 4) begin n_bad++; $display("FAIL restart_lat got %0d want 4", at - r); end
  endtask

  task automatic test_irq_boundary();
    int r, at;
    b0.irq_clr[0] = 1'b1; step(); b0.irq_clr = 4'b0000;
    n_cmp++; if (b0.irq_pend[0] !== 1'b0) begin n_bad++; $display("FAIL irq_clr got %b want 0", b0.irq_pend[0]); end
    cfg0(0, 1, 1'b0);
    start0(0);
    wait_tick0();
    b0.irq_clr[0] = 1'b1; step(); b0.irq_clr = 4'b0000;
    n_cmp++; if (b0.expire[0] !== 1'b1) begin n_bad++; $display("FAIL coin_expire got %b want 1", b0.expire[0]); end
    n_cmp++; if (b0.irq_pend[0] !== 1'b1) begin n_bad++; $display("FAIL coin_irq got %b want 1", b0.irq_pend[0]); end
    b0.irq_clr[0] = 1'b1; step(); b0.irq_clr = 4'b0000;
    n_cmp++; if (b0.irq_pend[0] !== 1'b0) begin n_bad++; $display("FAIL irq_clr2 got %b want 0", b0.irq_pend[0]); end
    // NCH=3 bank: channel index 3 is out of range and must be dropped
    cfg1(3, 2, 1'b0);
    b1.start = 3'b111; step(); b1.start = 3'b000;
    n_cmp++; if (b1.busy !== 3'b000) begin n_bad++; $display("FAIL bad_ch got %b want 000", b1.busy); end
    cfg1(0, 2, 1'b0);
    b1.start = 3'b001; step(); b1.start = 3'b000;
    r = cyc;
    n_cmp++; if (b1.busy !== 3'b001) begin n_bad++; $display("FAIL pre1_busy got %b want 001", b1.busy); end
    at = -1;
    for (int k = 0; k < 6; k++) begin
      step();
      if (b1.expire[0]) begin at = cyc; break; end
    end
    n_cmp++; if (at - r !== 2) begin n_bad++; $display("FAIL pre1_lat got %0d want 2", at - r); end
    // Reset in the middle of a count
    cfg0(1, 5, 1'b1);
    start0(1);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({b0.tick, b0.busy, b0.expire, b0.irq_pend} !== 13'd0) begin
      n_bad++; $display("FAIL midrst got %b want 0", {b0.tick, b0.busy, b0.expire, b0.irq_pend});
    end
    step();
    rst_n = 1'b1;
    step();
    n_cmp++; if (b0.busy !== 4'b0000) begin n_bad++; $display("FAIL post_rst_busy got %b want 0000", b0.busy); end
    start0(1);
    n_cmp++; if (b0.busy[1] !== 1'b0) begin n_bad++; $display("FAIL post_rst_period got %b want 0", b0.busy[1]); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc = 0;
    test_reset();
    test_oneshot();
    test_periodic();
    test_priority();
    test_irq_boundary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
